soc_simple_mem_arbiter: RTL and testbench
=========================================

# soc_simple_mem_arbiter

Two-master arbiter that shares the single-port 1024×32 on-chip program/data memory between the core's instruction-fetch port and its load/store port. It sits between the core and the memory. It grants one access per cycle and routes the one-cycle-latency read data back to the correct requester with a registered tag. It also keeps the instruction port from starving under sustained data traffic.

## Interface
- STARVE_LIMIT, default 8: contested cycles an instruction read may lose before it is forced through (guard build only).
- ADDR_W, default 12: requester byte-address width; word index is address[11:2].
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_read  in  1  instruction read request; held until accepted.
- i_address  in  ADDR_W  instruction byte address.
- i_waitrequest  out  1  high = request not accepted this cycle.
- i_readdata  out  32  fetch data.
- i_readdatavalid  out  1  i_readdata valid.
- d_read, d_write  in  1 each  data read / write request; held until accepted.
- d_address  in  ADDR_W  data byte address.
- d_byteenable  in  4  write byte lanes.
- d_writedata  in  32  write data.
- d_waitrequest  out  1  high = request not accepted this cycle.
- d_readdata  out  32  load data.
- d_readdatavalid  out  1  d_readdata valid.
- m_chipselect, m_write  out  1 each  memory strobes.
- m_address  out  10  memory word address.
- m_byteenable  out  4  memory byte enables.
- m_writedata  out  32  memory write data.
- m_clken  out  1  memory clock enable; constant 1 out of reset.
- m_readdata  in  32  memory read data, valid the cycle after the access.

## Operation
- Grant is combinational each cycle:
  - Data request (d_read|d_write) wins over i_read, except when the starvation guard fires.
  - Only one requester requesting: it is granted.
- The granted port's waitrequest is low; the losing requesting port's waitrequest is high. An idle port's waitrequest is low, with don't-care meaning.
- m_* is driven from the granted port:
  - m_address = address[11:2]; address[1:0] ignored.
  - Reads force m_byteenable=4'hF and m_write=0.
  - m_chipselect=0 when nothing is granted.
- d_read and d_write together is illegal; the access is treated as a write and produces no read response.
- A write with d_byteenable=0 is still issued and consumes the slot; memory is unchanged.
- Response tag register rtag ∈ {NONE, INSTR, DATA}: loaded each cycle with the owner of a granted read, NONE otherwise.
  - rtag=INSTR → i_readdatavalid=1. rtag=DATA → d_readdatavalid=1.
  - Both readdata outputs pass m_readdata through.
- Back-to-back reads from one port are accepted every cycle: full throughput, one response per cycle.
- Writes produce no response.

## Timing
- Reset values: rtag=NONE, both readdatavalid=0, m_chipselect=0, m_write=0, m_clken=1, starvation counter=0, waitrequests=0.
- Read issued (granted) in cycle N → readdatavalid high for exactly cycle N+1.
- Write granted in cycle N → memory updated at the end of N; a read of the same word granted in N+1 returns new data in N+2.
- reset_n asserted with a read in flight: the response is dropped; no readdatavalid after reset release until a new grant.
- Requests must be held stable while waitrequest is high; the arbiter does not register requests.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - Counter scnt (width clog2(STARVE_LIMIT+1)) increments each cycle i_read is high and denied; it saturates.
  - While scnt==STARVE_LIMIT, the instruction port wins the next contested cycle.
  - scnt clears on any instruction grant.
- ARB_STARVE_GUARD_EN undefined: strict data priority, no counter, STARVE_LIMIT unused.

## Structure
- Package soc_simple_mem_pkg holds:
  - constants MEM_WORDS=1024, MEM_AW=10, DATA_W=32, BE_W=4;
  - typedef rtag_t enum {RT_NONE, RT_INSTR, RT_DATA}.
- One sub-module, soc_simple_arb_prio: grant decision plus starvation counter (counter present only under ARB_STARVE_GUARD_EN). Tag routing and muxing stay in the top.

## Test plan
- Reset: hold reset_n=0 with both ports requesting → all outputs at reset values, m_chipselect=0.
- Solo instruction stream: i_read on 0x000,0x004,0x008 in consecutive cycles → i_waitrequest=0 each cycle; i_readdatavalid in the 3 following cycles with words 0,1,2.
- Contention, guard off: i_read and d_read both held 5 cycles → d granted 5 times, i_waitrequest=1 throughout.
- Contention, guard on, STARVE_LIMIT=8: d_read and i_read held continuously → i granted at the 9th contested cycle, scnt back to 0.
- Byte write then read: d_write 0x010, be=4'b0010, data 0xAABBCCDD over word 0x11223344 → next read returns 0x1122CC44 one cycle after grant.
- Reset mid-read: d_read granted, reset_n low the next cycle → no d_readdatavalid; first post-reset read responds normally.

Source files
------------

// File: rtl/soc_simple_mem_pkg.sv
// Shared constants and the response-tag type for the on-chip program/data
// memory arbiter.
package soc_simple_mem_pkg;

    localparam int unsigned MEM_WORDS = 1024;
    localparam int unsigned MEM_AW    = 10;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BE_W      = 4;

    // Owner of the read whose data returns from memory in the current cycle
    typedef enum logic [1:0] {
        RT_NONE  = 2'd0,
        RT_INSTR = 2'd1,
        RT_DATA  = 2'd2
    } rtag_t;

endpackage

// File: rtl/soc_simple_arb_prio.sv
// Grant decision between the instruction and data ports.
// Data wins by default. With ARB_STARVE_GUARD_EN defined, a saturating
// counter tracks instruction denials. Once the count reaches STARVE_LIMIT,
// the next contested cycle goes to the instruction port.
// Both grants are held low while reset_n is asserted.
module soc_simple_arb_prio
    import soc_simple_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_instr_req,
    input  logic i_data_req,
    output logic o_grant_instr,
    output logic o_grant_data
);

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned SCNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STARVE_LIMIT);

    logic [SCNT_W-1:0] r_scnt;
    logic              w_force_instr;

    assign w_force_instr = (r_scnt == SCNT_MAX);

    // Data priority unless the starvation count has saturated
    always_comb begin
        o_grant_data  = reset_n & i_data_req & ~(i_instr_req & w_force_instr);
        o_grant_instr = reset_n & i_instr_req & ~o_grant_data;
    end

    // Count instruction denials (saturating); clear on any instruction grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scnt <= '0;
        end else if (o_grant_instr) begin
            r_scnt <= '0;
        end else if (i_instr_req && (r_scnt != SCNT_MAX)) begin
            r_scnt <= r_scnt + SCNT_W'(1);
        end
    end
`else
    logic w_unused;
    assign w_unused = &{1'b0, clk, 32'(STARVE_LIMIT)};

    // Strict data priority
    always_comb begin
        o_grant_data  = reset_n & i_data_req;
        o_grant_instr = reset_n & i_instr_req & ~i_data_req;
    end
`endif

endmodule

// File: rtl/soc_simple_mem_arbiter.sv
// Two-master arbiter for the single-port 1024x32 program/data memory.
// The arbiter grants one access per cycle and routes the read data back
// using a registered tag. The starvation guard is compiled in only when
// ARB_STARVE_GUARD_EN is defined.
module soc_simple_mem_arbiter
    import soc_simple_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned ADDR_W       = 12
) (
    input  logic                clk,
    input  logic                reset_n,
    // instruction fetch port
    input  logic                i_read,
    input  logic [ADDR_W-1:0]   i_address,
    output logic                i_waitrequest,
    output logic [DATA_W-1:0]   i_readdata,
    output logic                i_readdatavalid,
    // load/store port
    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic [BE_W-1:0]     d_byteenable,
    input  logic [DATA_W-1:0]   d_writedata,
    output logic                d_waitrequest,
    output logic [DATA_W-1:0]   d_readdata,
    output logic                d_readdatavalid,
    // memory side
    output logic                m_chipselect,
    output logic                m_write,
    output logic [MEM_AW-1:0]   m_address,
    output logic [BE_W-1:0]     m_byteenable,
    output logic [DATA_W-1:0]   m_writedata,
    output logic                m_clken,
    input  logic [DATA_W-1:0]   m_readdata
);

    logic  w_d_req;
    logic  w_grant_i;
    logic  w_grant_d;
    logic  w_write;
    rtag_t w_next_tag;
    rtag_t r_rtag;
    logic  w_unused;

    // Address byte offsets and any bits above the word index are ignored
    assign w_unused = &{1'b0, i_address, d_address};

    assign w_d_req = d_read | d_write;

    soc_simple_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_instr_req   (i_read),
        .i_data_req    (w_d_req),
        .o_grant_instr (w_grant_i),
        .o_grant_data  (w_grant_d)
    );

    // A data request with both read and write set is issued as a write
    assign w_write = w_grant_d & d_write;

    // Drive the memory from the granted port
    always_comb begin
        m_chipselect = w_grant_i | w_grant_d;
        m_write      = w_write;
        m_address    = w_grant_d ? d_address[MEM_AW+1:2] : i_address[MEM_AW+1:2];
        m_byteenable = w_write ? d_byteenable : '1;
        m_writedata  = d_writedata;
        m_clken      = 1'b1;
    end

    // Only a requesting port that lost the grant is stalled
    always_comb begin
        i_waitrequest = reset_n & i_read  & ~w_grant_i;
        d_waitrequest = reset_n & w_d_req & ~w_grant_d;
    end

    // Owner of a read granted this cycle, if any
    always_comb begin
        w_next_tag = RT_NONE;
        if (w_grant_i) begin
            w_next_tag = RT_INSTR;
        end else if (w_grant_d && d_read && !d_write) begin
            w_next_tag = RT_DATA;
        end
    end

    // Response tag for the read data arriving next cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rtag <= RT_NONE;
        end else begin
            r_rtag <= w_next_tag;
        end
    end

    // Steer the read-data valid signal to the port that issued the read
    always_comb begin
        i_readdatavalid = (r_rtag == RT_INSTR);
        d_readdatavalid = (r_rtag == RT_DATA);
        i_readdata      = m_readdata;
        d_readdata      = m_readdata;
    end

endmodule

// File: tb/tb_soc_simple_mem_arbiter.sv
// Directed bench for soc_simple_mem_arbiter with a behavioural 1024x32
// byte-enabled memory that has one-cycle read latency.
// Inputs change on the falling edge. Combinational outputs are sampled 1
// time unit later. Registered outputs are sampled on the following falling
// edge.
// With ARB_STARVE_GUARD_EN defined, the bench also runs the starvation test.
module tb_soc_simple_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_read = 1'b0;
    logic [11:0] i_address = '0;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic        i_readdatavalid;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [11:0] d_address = '0;
    logic [3:0]  d_byteenable = '0;
    logic [31:0] d_writedata = '0;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic        d_readdatavalid;
    logic        m_chipselect;
    logic        m_write;
    logic [9:0]  m_address;
    logic [3:0]  m_byteenable;
    logic [31:0] m_writedata;
    logic        m_clken;
    logic [31:0] m_readdata = '0;

    logic [31:0] mem [1024];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    soc_simple_mem_arbiter #(
        .STARVE_LIMIT (8),
        .ADDR_W       (12)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_read          (i_read),
        .i_address       (i_address),
        .i_waitrequest   (i_waitrequest),
        .i_readdata      (i_readdata),
        .i_readdatavalid (i_readdatavalid),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_address       (d_address),
        .d_byteenable    (d_byteenable),
        .d_writedata     (d_writedata),
        .d_waitrequest   (d_waitrequest),
        .d_readdata      (d_readdata),
        .d_readdatavalid (d_readdatavalid),
        .m_chipselect    (m_chipselect),
        .m_write         (m_write),
        .m_address       (m_address),
        .m_byteenable    (m_byteenable),
        .m_writedata     (m_writedata),
        .m_clken         (m_clken),
        .m_readdata      (m_readdata)
    );

    // Memory model
    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 32'hC0DE_0000 | 32'(k);
    end

    always @(posedge clk) begin
        if (m_clken && m_chipselect) begin
            if (m_write) begin
                for (int b = 0; b < 4; b++)
                    if (m_byteenable[b]) mem[m_address][b*8 +: 8] = m_writedata[b*8 +: 8];
            end else begin
                m_readdata <= mem[m_address];
            end
        end
    end

    task automatic idle_inputs();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = '0; d_address = '0; d_byteenable = '0; d_writedata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        i_read = 1'b1; i_address = 12'h040;
        d_read = 1'b1; d_address = 12'h080;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (i_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rst_i_wait got=%b exp=0", i_waitrequest); end
        n_tests++; if (d_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rst_d_wait got=%b exp=0", d_waitrequest); end
        n_tests++; if (i_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rst_i_valid got=%b exp=0", i_readdatavalid); end
        n_tests++; if (d_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rst_d_valid got=%b exp=0", d_readdatavalid); end
        n_tests++; if (m_chipselect !== 1'b0) begin n_fail++; $display("FAIL rst_cs got=%b exp=0", m_chipselect); end
        n_tests++; if (m_write !== 1'b0) begin n_fail++; $display("FAIL rst_wr got=%b exp=0", m_write); end
        n_tests++; if (m_clken !== 1'b1) begin n_fail++; $display("FAIL rst_clken got=%b exp=1", m_clken); end
        idle_inputs();
        reset_n = 1'b1;
    endtask

    task automatic test_solo_instr();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i_read = 1'b1; i_address = 12'(k * 4);
            #1;
            n_tests++; if (i_waitrequest !== 1'b0) begin n_fail++; $display("FAIL solo_wait[%0d] got=%b exp=0", k, i_waitrequest); end
            n_tests++; if (m_address !== 10'(k)) begin n_fail++; $display("FAIL solo_maddr[%0d] got=%0d exp=%0d", k, m_address, k); end
            if (k == 0) begin
                n_tests++; if (i_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL solo_valid_first got=%b exp=0", i_readdatavalid); end
            end else begin
                n_tests++; if (i_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL solo_valid[%0d] got=%b exp=1", k-1, i_readdatavalid); end
                n_tests++; if (i_readdata !== (32'hC0DE_0000 | 32'(k-1))) begin n_fail++; $display("FAIL solo_data[%0d] got=%h exp=%h", k-1, i_readdata, 32'hC0DE_0000 | 32'(k-1)); end
            end
        end
        @(negedge clk);
        i_read = 1'b0;
        #1;
        n_tests++; if (i_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL solo_valid[2] got=%b exp=1", i_readdatavalid); end
        n_tests++; if (i_readdata !== 32'hC0DE_0002) begin n_fail++; $display("FAIL solo_data[2] got=%h exp=c0de0002", i_readdata); end
        @(negedge clk);
        #1;
        n_tests++; if (i_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL solo_valid_after got=%b exp=0", i_readdatavalid); end
    endtask

    task automatic test_contention();
        int d_grants;
        d_grants = 0;
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            i_read = 1'b1; i_address = 12'h200;
            d_read = 1'b1; d_address = 12'h100;
            #1;
            n_tests++; if (i_waitrequest !== 1'b1) begin n_fail++; $display("FAIL cont_i_wait[%0d] got=%b exp=1", c, i_waitrequest); end
            if (d_waitrequest === 1'b0 && m_chipselect === 1'b1 && m_address === 10'd64) d_grants++;
            if (c > 0) begin
                n_tests++; if ({i_readdatavalid, d_readdatavalid} !== 2'b01) begin n_fail++; $display("FAIL cont_valid[%0d] got=%b%b exp=01", c, i_readdatavalid, d_readdatavalid); end
            end
        end
        n_tests++; if (d_grants !== 5) begin n_fail++; $display("FAIL cont_d_grants got=%0d exp=5", d_grants); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++; if (d_readdata !== 32'hC0DE_0040) begin n_fail++; $display("FAIL cont_d_data got=%h exp=c0de0040", d_readdata); end
    endtask

`ifdef ARB_STARVE_GUARD_EN
    task automatic test_starve_guard();
        apply_reset();
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            i_read = 1'b1; i_address = 12'h200;
            d_read = 1'b1; d_address = 12'h100;
            #1;
            if (c == 9 || c == 18) begin
                n_tests++; if ({i_waitrequest, d_waitrequest} !== 2'b01) begin n_fail++; $display("FAIL starve_force[%0d] got i=%b d=%b exp i=0 d=1", c, i_waitrequest, d_waitrequest); end
                n_tests++; if (m_address !== 10'd128) begin n_fail++; $display("FAIL starve_maddr[%0d] got=%0d exp=128", c, m_address); end
            end else begin
                n_tests++; if ({i_waitrequest, d_waitrequest} !== 2'b10) begin n_fail++; $display("FAIL starve_dwin[%0d] got i=%b d=%b exp i=1 d=0", c, i_waitrequest, d_waitrequest); end
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++; if (i_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL starve_i_valid got=%b exp=1", i_readdatavalid); end
    endtask
`endif

    task automatic test_byte_write();
        apply_reset();
        mem[4] = 32'h1122_3344;
        mem[8] = 32'h5566_7788;
        @(negedge clk);
        d_write = 1'b1; d_address = 12'h010; d_byteenable = 4'b0010; d_writedata = 32'hAABB_CCDD;
        #1;
        n_tests++; if ({m_chipselect, m_write, m_byteenable, m_address} !== {1'b1, 1'b1, 4'b0010, 10'd4}) begin n_fail++; $display("FAIL bw_issue got cs=%b wr=%b be=%b a=%0d exp cs=1 wr=1 be=0010 a=4", m_chipselect, m_write, m_byteenable, m_address); end
        @(negedge clk);
        d_write = 1'b0; d_read = 1'b1; d_byteenable = 4'b0000;
        #1;
        n_tests++; if ({m_write, m_byteenable} !== {1'b0, 4'hF}) begin n_fail++; $display("FAIL bw_read_be got wr=%b be=%b exp wr=0 be=1111", m_write, m_byteenable); end
        n_tests++; if (d_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL bw_write_noresp got=%b exp=0", d_readdatavalid); end
        @(negedge clk);
        d_read = 1'b0;
        d_write = 1'b1; d_address = 12'h020; d_byteenable = 4'b0000; d_writedata = 32'hFFFF_FFFF;
        #1;
        n_tests++; if ({d_readdatavalid, d_readdata} !== {1'b1, 32'h1122_CC44}) begin n_fail++; $display("FAIL bw_readback got v=%b d=%h exp v=1 d=1122cc44", d_readdatavalid, d_readdata); end
        n_tests++; if ({m_chipselect, m_write} !== 2'b11) begin n_fail++; $display("FAIL bw_be0_issue got cs=%b wr=%b exp 11", m_chipselect, m_write); end
        @(negedge clk);
        d_write = 1'b1; d_read = 1'b1; d_address = 12'h024; d_byteenable = 4'hF; d_writedata = 32'h0BAD_F00D;
        #1;
        n_tests++; if (m_write !== 1'b1) begin n_fail++; $display("FAIL rw_as_write got=%b exp=1", m_write); end
        @(negedge clk);
        d_write = 1'b0; d_read = 1'b1; d_address = 12'h020;
        #1;
        n_tests++; if (d_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rw_noresp got=%b exp=0", d_readdatavalid); end
        @(negedge clk);
        d_read = 1'b1; d_address = 12'h024;
        #1;
        n_tests++; if ({d_readdatavalid, d_readdata} !== {1'b1, 32'h5566_7788}) begin n_fail++; $display("FAIL be0_unchanged got v=%b d=%h exp v=1 d=55667788", d_readdatavalid, d_readdata); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++; if ({d_readdatavalid, d_readdata} !== {1'b1, 32'h0BAD_F00D}) begin n_fail++; $display("FAIL rw_written got v=%b d=%h exp v=1 d=0badf00d", d_readdatavalid, d_readdata); end
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        @(negedge clk);
        d_read = 1'b1; d_address = 12'h004;
        #1;
        n_tests++; if (d_waitrequest !== 1'b0) begin n_fail++; $display("FAIL mid_grant got=%b exp=0", d_waitrequest); end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        d_read = 1'b0;
        #1;
        n_tests++; if (d_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL mid_dropped got=%b exp=0", d_readdatavalid); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            n_tests++; if (d_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL mid_post_idle[%0d] got=%b exp=0", c, d_readdatavalid); end
        end
        @(negedge clk);
        d_read = 1'b1; d_address = 12'h008;
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++; if ({d_readdatavalid, d_readdata} !== {1'b1, 32'hC0DE_0002}) begin n_fail++; $display("FAIL mid_post_read got v=%b d=%h exp v=1 d=c0de0002", d_readdatavalid, d_readdata); end
    endtask

    initial begin
        test_reset();
        test_solo_instr();
        test_contention();
`ifdef ARB_STARVE_GUARD_EN
        test_starve_guard();
`endif
        test_byte_write();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
